// File: rtl/commit_unit.sv
// commit_unit: retires ROB commit entries as register writes, exception flushes or halt.
// Optional COMMIT_PERF_EN adds a stall_count output.
module commit_unit #(
  parameter int N_ROB_W      = 4,
  parameter int REG_ADDR_W   = 6,
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [N_ROB_W-1:0]    c_rob_id,
  input  logic [REG_ADDR_W-1:0] c_dst_reg,
  input  logic [DATA_W-1:0]     c_content,
  input  logic [DATA_W-1:0]     c_pc,
  input  logic                  c_no_wb,
  input  logic                  c_exception,
  input  logic                  c_halt,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [N_ROB_W-1:0]    wb_rob_id,
  output logic                  clear,
  output logic                  exc_valid,
  output logic [DATA_W-1:0]     exc_pc,
  output logic                  halted,
`ifdef COMMIT_PERF_EN
  output logic [31:0]           stall_count,
`endif
  output logic [31:0]           commit_count
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  logic [1:0] state;
  logic [CW-1:0] flush_cnt;
  logic acc, exc, wr;
  assign c_ready = state == RUN;
  assign clear   = state == FLUSH;
  assign halted  = state == HALT;
  assign acc     = c_valid & c_ready;
  assign exc     = acc & c_exception;
  assign wr      = acc & ~c_exception & ~c_no_wb & (c_dst_reg != '0);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= RUN;
      flush_cnt    <= '0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      wb_rob_id    <= '0;
      exc_valid    <= 1'b0;
      exc_pc       <= '0;
      commit_count <= '0;
    end else begin
      wb_valid  <= wr;
      exc_valid <= exc;
      if (wr) begin
        wb_addr   <= c_dst_reg;
        wb_data   <= c_content;
        wb_rob_id <= c_rob_id;
      end
      if (exc) exc_pc <= c_pc;
      if (acc & ~c_exception) commit_count <= commit_count + 32'd1;
      // flush_cnt counts remaining clear cycles after the first
      if (exc) begin
        state     <= FLUSH;
        flush_cnt <= CW'(FLUSH_CYCLES - 1);
      end else if (acc & c_halt) begin
        state <= HALT;
      end else if (state == FLUSH) begin
        if (flush_cnt == '0) state <= RUN;
        else flush_cnt <= flush_cnt - CW'(1);
      end
    end
  end
`ifdef COMMIT_PERF_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) stall_count <= '0;
    else if ((state == RUN & ~c_valid) | state == FLUSH) stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed checks of commit_unit writes, exception flush, halt and async reset.
module tb_commit_unit;
  logic clk = 1'b0, nrst = 1'b0;
  logic c_valid = 1'b0, c_ready;
  logic [3:0] c_rob_id = '0;
  logic [5:0] c_dst_reg = '0;
  logic [31:0] c_content = '0, c_pc = '0;
  logic c_no_wb = 1'b0, c_exception = 1'b0, c_halt = 1'b0;
  logic wb_valid, clear, exc_valid, halted;
  logic [5:0] wb_addr;
  logic [31:0] wb_data, exc_pc, commit_count;
  logic [3:0] wb_rob_id;
`ifdef COMMIT_PERF_EN
  logic [31:0] stall_count;
`endif
  int pass = 0, total = 0;

  commit_unit dut (
    .clk(clk), .nrst(nrst), .c_valid(c_valid), .c_ready(c_ready), .c_rob_id(c_rob_id),
    .c_dst_reg(c_dst_reg), .c_content(c_content), .c_pc(c_pc), .c_no_wb(c_no_wb),
    .c_exception(c_exception), .c_halt(c_halt), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_rob_id(wb_rob_id), .clear(clear), .exc_valid(exc_valid),
    .exc_pc(exc_pc), .halted(halted),
`ifdef COMMIT_PERF_EN
    .stall_count(stall_count),
`endif
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] id, input logic [5:0] dst,
                       input logic [31:0] data, input logic [31:0] pc,
                       input logic nowb, input logic ex, input logic hl);
    c_valid = v; c_rob_id = id; c_dst_reg = dst; c_content = data; c_pc = pc;
    c_no_wb = nowb; c_exception = ex; c_halt = hl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #2;
    total++; if (c_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", c_ready); else pass++;
    total++; if ({wb_valid, clear, exc_valid, halted} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {wb_valid, clear, exc_valid, halted}); else pass++;
    total++; if (commit_count !== 32'd0) $display("FAIL rst_count got %0d exp 0", commit_count); else pass++;
    total++; if (exc_pc !== 32'd0 || wb_data !== 32'd0) $display("FAIL rst_data got %h/%h exp 0/0", exc_pc, wb_data); else pass++;
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_write();
    drive(1, 3, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (wb_valid !== 1'b1) $display("FAIL wr_valid got %b exp 1", wb_valid); else pass++;
    total++; if (wb_addr !== 6'd5) $display("FAIL wr_addr got %0d exp 5", wb_addr); else pass++;
    total++; if (wb_data !== 32'hDEADBEEF) $display("FAIL wr_data got %h exp deadbeef", wb_data); else pass++;
    total++; if (wb_rob_id !== 4'd3) $display("FAIL wr_id got %0d exp 3", wb_rob_id); else pass++;
    total++; if (commit_count !== 32'd1) $display("FAIL wr_count got %0d exp 1", commit_count); else pass++;
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL wr_strobe got %b exp 0", wb_valid); else pass++;
    total++; if (wb_data !== 32'hDEADBEEF) $display("FAIL wr_hold got %h exp deadbeef", wb_data); else pass++;
  endtask

  task automatic test_x0_f0();
    do_reset();
    drive(1, 2, 0, 32'h12345678, 0, 0, 0, 0);
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL x0_valid got %b exp 0", wb_valid); else pass++;
    total++; if (commit_count !== 32'd1) $display("FAIL x0_count got %0d exp 1", commit_count); else pass++;
    drive(1, 4, 32, 32'h3F800000, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (wb_valid !== 1'b1 || wb_addr !== 6'd32) $display("FAIL f0_wr got %b/%0d exp 1/32", wb_valid, wb_addr); else pass++;
    total++; if (wb_data !== 32'h3F800000) $display("FAIL f0_data got %h exp 3f800000", wb_data); else pass++;
    total++; if (commit_count !== 32'd2) $display("FAIL f0_count got %0d exp 2", commit_count); else pass++;
    drive(1, 6, 9, 32'h55, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (wb_valid !== 1'b0 || commit_count !== 32'd3) $display("FAIL nowb got %b/%0d exp 0/3", wb_valid, commit_count); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ids [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, ids[i], 6'(i + 1), 32'(i * 16), 0, 0, 0, 0);
      step();
      total++; if (wb_valid !== 1'b1 || wb_rob_id !== ids[i] || wb_addr !== 6'(i + 1)) $display("FAIL b2b_%0d got %b/%0d/%0d exp 1/%0d/%0d", i, wb_valid, wb_rob_id, wb_addr, ids[i], i + 1); else pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL b2b_idle got %b exp 0", wb_valid); else pass++;
    total++; if (commit_count !== 32'd4) $display("FAIL b2b_count got %0d exp 4", commit_count); else pass++;
  endtask

  task automatic test_exception();
    drive(1, 5, 9, 32'hAA, 32'h100, 0, 1, 1);
    step();
    drive(1, 6, 10, 32'hBB, 32'h200, 0, 0, 0);
    total++; if (exc_valid !== 1'b1 || exc_pc !== 32'h100) $display("FAIL exc_pulse got %b/%h exp 1/100", exc_valid, exc_pc); else pass++;
    total++; if (clear !== 1'b1 || c_ready !== 1'b0) $display("FAIL exc_f1 got clr %b rdy %b exp 1/0", clear, c_ready); else pass++;
    total++; if (wb_valid !== 1'b0 || commit_count !== 32'd4 || halted !== 1'b0) $display("FAIL exc_nowr got %b/%0d/%b exp 0/4/0", wb_valid, commit_count, halted); else pass++;
    step();
    total++; if (exc_valid !== 1'b0 || clear !== 1'b1 || c_ready !== 1'b0) $display("FAIL exc_f2 got %b/%b/%b exp 0/1/0", exc_valid, clear, c_ready); else pass++;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (clear !== 1'b0 || c_ready !== 1'b1) $display("FAIL exc_end got clr %b rdy %b exp 0/1", clear, c_ready); else pass++;
    total++; if (wb_valid !== 1'b0 || commit_count !== 32'd4 || exc_pc !== 32'h100) $display("FAIL exc_ign got %b/%0d/%h exp 0/4/100", wb_valid, commit_count, exc_pc); else pass++;
  endtask

  task automatic test_halt();
    int bad = 0;
    drive(1, 7, 7, 32'h77, 32'h300, 0, 0, 1);
    step();
    drive(1, 8, 11, 32'h88, 0, 0, 0, 0);
    total++; if (wb_valid !== 1'b1 || wb_addr !== 6'd7 || wb_data !== 32'h77) $display("FAIL halt_wr got %b/%0d/%h exp 1/7/77", wb_valid, wb_addr, wb_data); else pass++;
    total++; if (halted !== 1'b1 || commit_count !== 32'd5) $display("FAIL halt_state got %b/%0d exp 1/5", halted, commit_count); else pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (c_ready !== 1'b0 || halted !== 1'b1 || wb_valid !== 1'b0) bad++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (bad !== 0) $display("FAIL halt_hold got %0d bad cycles exp 0", bad); else pass++;
    total++; if (commit_count !== 32'd5) $display("FAIL halt_count got %0d exp 5", commit_count); else pass++;
    #2 nrst = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || commit_count !== 32'd0 || c_ready !== 1'b1) $display("FAIL halt_rst got %b/%0d/%b exp 0/0/1", halted, commit_count, c_ready); else pass++;
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_flush_reset();
    drive(1, 1, 2, 32'h1, 32'h400, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++; if (clear !== 1'b1) $display("FAIL frst_pre got %b exp 1", clear); else pass++;
    #2 nrst = 1'b0;
    #1;
    total++; if (clear !== 1'b0 || c_ready !== 1'b1) $display("FAIL frst_clr got %b/%b exp 0/1", clear, c_ready); else pass++;
`ifdef COMMIT_PERF_EN
    total++; if (stall_count !== 32'd0) $display("FAIL frst_stall got %0d exp 0", stall_count); else pass++;
`endif
    step();
    nrst = 1'b1;
    step();
    total++; if (c_ready !== 1'b1 || clear !== 1'b0 || exc_pc !== 32'd0) $display("FAIL frst_run got %b/%b/%h exp 1/0/0", c_ready, clear, exc_pc); else pass++;
`ifdef COMMIT_PERF_EN
    step();
    total++; if (stall_count !== 32'd2) $display("FAIL stall_idle got %0d exp 2", stall_count); else pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_x0_f0();
    test_back_to_back();
    test_exception();
    test_halt();
    test_flush_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
